btn_hex_entry: RTL and testbench
================================

# btn_hex_entry

Front-panel input block: turns the two active-low push buttons into a 16-bit hex argument, entered one nibble at a time, and hands it to the compute core over a valid/ready handshake. It feeds the `led_decoder` display path (current value and selected digit), and its handshake output drives the argument/start side of the core whose result the display path shows.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable synchronized samples needed to accept a button level change (≥2).
- `LONG_CYCLES`, default 25000000: debounced hold time on btn2 that counts as a long press (> `DEBOUNCE_CYCLES`).
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn1_n`  in  1  raw button 1, active low, asynchronous to `clk`.
- `btn2_n`  in  1  raw button 2, active low, asynchronous to `clk`.
- `value`  out  16  argument being edited; goes to the hex display.
- `digit_sel`  out  2  selected nibble index (0 = bits 3:0).
- `busy`  out  1  high while in SEND.
- `arg_valid`  out  1  argument offer to the consumer.
- `arg_data`  out  16  argument; equals `value` while `arg_valid`.
- `arg_ready`  in  1  consumer accept.

## Operation
- Per button: 2-flop synchronizer, then debouncer.
  - The debounced level starts at released (1).
  - It flips when the synchronized sample differs from it for `DEBOUNCE_CYCLES` consecutive clocks.
  - Any matching sample clears the counter.
- Events are 1-cycle pulses registered the clock after the debounced level flips: `press1`, `press2`, `release2`.
- btn2 hold counter:
  - Counts while btn2 is debounced-pressed and saturates.
  - `long2` pulses once when the count reaches `LONG_CYCLES`.
  - It clears on release.
- State EDIT (the reset state):
  - `press1`: nibble `digit_sel` of `value` increments mod 16. F→0 wraps with no carry into other nibbles.
  - `release2` with no `long2` seen during this hold: `digit_sel` increments mod 4 (3→0).
  - `long2`: go to SEND. No digit advance on the later release.
  - `press1` and `release2` in the same cycle: the increment hits the old digit, then `digit_sel` advances.
  - `press1` and `long2` in the same cycle: `long2` wins and `press1` is discarded.
- State SEND:
  - `arg_valid` = 1, `busy` = 1.
  - `value`, `digit_sel` and `arg_data` are frozen, and all button events are discarded.
  - Debouncers and the hold counter keep running.
  - `arg_valid && arg_ready` at a clock edge: go back to EDIT. `value` is kept and `digit_sel` is not changed.
- `arg_ready` is ignored in EDIT. `arg_valid` never drops without `arg_ready`.
- A btn2 release that follows a long press, including one that completes during SEND, never advances the digit.

## Timing
- Reset (synchronous, any state, including mid-SEND and mid-debounce):
  - `value` = 0, `digit_sel` = 0, `arg_valid` = 0, `busy` = 0, `arg_data` = 0, state EDIT.
  - Debounced levels = released; all counters = 0.
  - An offer in flight is dropped.
- Raw edge to event pulse:
  - 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1.
  - The edit is visible on `value`/`digit_sel` the cycle after the pulse.
- `long2`: `LONG_CYCLES` clocks after btn2 becomes debounced-pressed.
  - `arg_valid` rises the clock after `long2`.
- Handshake: the transfer completes on the clock edge where `arg_valid` and `arg_ready` are both high.
  - `arg_valid` is low the next cycle, so there are no back-to-back offers.
  - Minimum time from one transfer to the next is a new `long2`.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Parameters for all tests: `DEBOUNCE_CYCLES` = 4, `LONG_CYCLES` = 20.
- Bounce: `btn1_n` toggles every 2 cycles for 30 cycles, then holds low → exactly one increment; `value` 0x0000→0x0001, timed per the raw-edge latency.
- Wrap and digit: 17 clean btn1 presses → `value` = 0x0001. One short btn2 press (held 8 cycles) → `digit_sel` = 1. Three btn1 presses → `value` = 0x0031. Four more short btn2 presses → `digit_sel` = 1 again (3→0 wrap).
- Long press: `value` 0x0031, btn2 held 40 cycles →
  - `arg_valid` rises once, with `arg_data` = 0x0031.
  - `digit_sel` is unchanged after release.
  - `arg_ready` held low 50 cycles while btn1 is pressed → `value` and `arg_valid` stay stable.
- Accept: `arg_ready` pulses 1 cycle → `arg_valid` and `busy` are low the next cycle, `value` is still 0x0031, and a following btn1 press gives 0x0032 (when `digit_sel` = 0).
- Simultaneous: a btn1 press event coincides with a short btn2 release at `digit_sel` = 0, `value` = 0x00F0 → `value` = 0x00F1 and `digit_sel` = 1.
- Reset mid-SEND: `reset` asserted while `arg_valid` = 1 → next cycle all outputs are 0, the state is EDIT, and `arg_ready` then has no effect.

Source files
------------

// File: rtl/btn_hex_entry.sv
// Two-button hex argument entry: btn1 bumps the selected nibble, a short btn2
// press selects the next nibble, a long btn2 press offers the value over valid/ready.
module btn_hex_entry #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn1_n,
  input  logic        btn2_n,
  output logic [15:0] value,
  output logic [1:0]  digit_sel,
  output logic        busy,
  output logic        arg_valid,
  output logic [15:0] arg_data,
  input  logic        arg_ready
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);

  typedef enum logic {S_EDIT, S_SEND} state_t;

  logic [1:0]        w_raw;
  logic [1:0]        w_db;
  logic [15:0]       w_value_inc;

  logic [1:0]        r_db_d;
  logic              r_press1;
  logic              r_release2;
  logic              r_long2;
  logic              r_long_seen;
  logic [LONG_W-1:0] r_hold_cnt;

  state_t            r_state;
  logic [15:0]       r_value;
  logic [1:0]        r_digit_sel;
  logic              r_busy;
  logic              r_arg_valid;
  logic [15:0]       r_arg_data;

  assign w_raw = {btn2_n, btn1_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            r_s1;
      logic            r_s2;
      logic            r_lvl;
      logic [DB_W-1:0] r_cnt;

      // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_s1  <= 1'b1;
          r_s2  <= 1'b1;
          r_lvl <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
          if (r_s2 == r_lvl) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_lvl <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_db[gi] = r_lvl;
    end

    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign w_value_inc[4*gi +: 4] = r_value[4*gi +: 4] + {3'b000, r_digit_sel == 2'(gi)};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_d      <= 2'b11;
      r_press1    <= 1'b0;
      r_release2  <= 1'b0;
      r_long2     <= 1'b0;
      r_long_seen <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_db_d     <= w_db;
      r_press1   <= r_db_d[0] & ~w_db[0];
      r_release2 <= ~r_db_d[1] & w_db[1];
      r_long2    <= ~w_db[1] && (r_hold_cnt == LONG_W'(LONG_CYCLES - 1));
      if (w_db[1])
        r_hold_cnt <= '0;
      else if (r_hold_cnt != LONG_W'(LONG_CYCLES))
        r_hold_cnt <= r_hold_cnt + 1'b1;
      // Remembers a long press until its release, even if that release lands in SEND.
      if (r_long2)
        r_long_seen <= 1'b1;
      else if (r_release2)
        r_long_seen <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_EDIT;
      r_value     <= '0;
      r_digit_sel <= '0;
      r_busy      <= 1'b0;
      r_arg_valid <= 1'b0;
      r_arg_data  <= '0;
    end else begin
      case (r_state)
        S_EDIT: begin
          if (r_long2) begin
            r_state     <= S_SEND;
            r_busy      <= 1'b1;
            r_arg_valid <= 1'b1;
            r_arg_data  <= r_value;
          end else begin
            if (r_press1)
              r_value <= w_value_inc;
            if (r_release2 && !r_long_seen)
              r_digit_sel <= r_digit_sel + 2'd1;
          end
        end
        S_SEND: begin
          if (arg_ready) begin
            r_state     <= S_EDIT;
            r_busy      <= 1'b0;
            r_arg_valid <= 1'b0;
          end
        end
        default: r_state <= S_EDIT;
      endcase
    end
  end

  assign value     = r_value;
  assign digit_sel = r_digit_sel;
  assign busy      = r_busy;
  assign arg_valid = r_arg_valid;
  assign arg_data  = r_arg_data;

endmodule

// File: tb/tb_btn_hex_entry.sv
// Bench for btn_hex_entry with DEBOUNCE_CYCLES=4, LONG_CYCLES=20: table-driven
// edit vectors plus hand-written bounce, long-press, handshake and reset sequences.
module tb_btn_hex_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn1_n;
  logic        btn2_n;
  logic [15:0] value;
  logic [1:0]  digit_sel;
  logic        busy;
  logic        arg_valid;
  logic [15:0] arg_data;
  logic        arg_ready;

  int checks = 0;
  int failures = 0;

  btn_hex_entry #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn1_n    (btn1_n),
    .btn2_n    (btn2_n),
    .value     (value),
    .digit_sel (digit_sel),
    .busy      (busy),
    .arg_valid (arg_valid),
    .arg_data  (arg_data),
    .arg_ready (arg_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] value;
    logic [1:0]  dsel;
    logic        valid;
    logic        busy;
    logic        chk_data;
    logic [15:0] data;
  } exp_t;

  typedef enum {OP_PRESS1, OP_SHORT2} op_t;

  typedef struct {
    op_t         op;
    int          reps;
    logic [15:0] value;
    logic [1:0]  dsel;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string n, input logic [15:0] v, input logic [1:0] d,
                            input logic vl, input logic b, input logic cd, input logic [15:0] dt);
    exp_t e;
    e.name = n; e.value = v; e.dsel = d; e.valid = vl; e.busy = b; e.chk_data = cd; e.data = dt;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard: actual empty queue, required a pending expectation");
    end else begin
      e = sb.pop_front();
      if (value !== e.value || digit_sel !== e.dsel || arg_valid !== e.valid ||
          busy !== e.busy || (e.chk_data && arg_data !== e.data)) begin
        failures++;
        $display("FAIL %s: actual value=%h dsel=%0d valid=%b busy=%b data=%h, required value=%h dsel=%0d valid=%b busy=%b data=%h%s",
                 e.name, value, digit_sel, arg_valid, busy, arg_data,
                 e.value, e.dsel, e.valid, e.busy, e.data, e.chk_data ? "" : "(unchecked)");
      end else begin
        $display("check %s: value=%h dsel=%0d valid=%b busy=%b data=%h ok",
                 e.name, value, digit_sel, arg_valid, busy, arg_data);
      end
    end
  endtask

  task automatic press1_clean();
    btn1_n = 1'b0;
    tick(10);
    btn1_n = 1'b1;
    tick(10);
  endtask

  task automatic short2();
    btn2_n = 1'b0;
    tick(8);
    btn2_n = 1'b1;
    tick(12);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual simulation still running, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{op: OP_PRESS1, reps: 17, value: 16'h0001, dsel: 2'd0};
    tbl[1] = '{op: OP_SHORT2, reps: 1,  value: 16'h0001, dsel: 2'd1};
    tbl[2] = '{op: OP_PRESS1, reps: 3,  value: 16'h0031, dsel: 2'd1};
    tbl[3] = '{op: OP_SHORT2, reps: 4,  value: 16'h0031, dsel: 2'd1};
    tbl[4] = '{op: OP_SHORT2, reps: 3,  value: 16'h0031, dsel: 2'd0};
    tbl[5] = '{op: OP_PRESS1, reps: 0,  value: 16'h0031, dsel: 2'd0};

    reset = 1'b1; btn1_n = 1'b1; btn2_n = 1'b1; arg_ready = 1'b0;
    expect_out("reset", 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick(3);
    check_pop();
    reset = 1'b0;
    tick(2);

    // Bounce: 2-cycle segments never reach 4 stable samples; final fall at i=28.
    expect_out("bounce_quiet", 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 28; i++) begin
      btn1_n = ((i >> 1) & 1) ? 1'b1 : 1'b0;
      tick(1);
    end
    check_pop();
    btn1_n = 1'b0;
    expect_out("bounce_at_pulse", 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
    expect_out("bounce_edit", 16'h0001, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick(7);
    check_pop();
    tick(1);
    check_pop();
    expect_out("bounce_once", 16'h0001, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick(20);
    btn1_n = 1'b1;
    tick(12);
    check_pop();

    do_reset();
    tick(2);
    for (int i = 0; i < 6; i++) begin
      expect_out($sformatf("vec%0d", i), tbl[i].value, tbl[i].dsel, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int r = 0; r < tbl[i].reps; r++) begin
        if (tbl[i].op == OP_PRESS1) press1_clean();
        else short2();
      end
      check_pop();
    end

    // Long press: debounced at +6, long2 at +26, arg_valid at +27.
    btn2_n = 1'b0;
    expect_out("long_pre", 16'h0031, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    expect_out("long_rise", 16'h0031, 2'd0, 1'b1, 1'b1, 1'b1, 16'h0031);
    tick(26);
    check_pop();
    tick(1);
    check_pop();
    tick(13);
    btn2_n = 1'b1;
    btn1_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_out($sformatf("send_hold%0d", k), 16'h0031, 2'd0, 1'b1, 1'b1, 1'b1, 16'h0031);
      tick(10);
      check_pop();
    end
    btn1_n = 1'b1;
    expect_out("send_after", 16'h0031, 2'd0, 1'b1, 1'b1, 1'b1, 16'h0031);
    tick(12);
    check_pop();

    arg_ready = 1'b1;
    expect_out("accept", 16'h0031, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick(1);
    arg_ready = 1'b0;
    check_pop();
    expect_out("post_accept_press", 16'h0032, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    press1_clean();
    check_pop();

    // Accept while btn2 is still held: the later release must not advance the digit.
    btn2_n = 1'b0;
    expect_out("long_again", 16'h0032, 2'd0, 1'b1, 1'b1, 1'b1, 16'h0032);
    tick(30);
    check_pop();
    arg_ready = 1'b1;
    expect_out("accept_held", 16'h0032, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick(1);
    arg_ready = 1'b0;
    check_pop();
    tick(5);
    btn2_n = 1'b1;
    expect_out("release_after_long", 16'h0032, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick(12);
    check_pop();
    expect_out("short_after_long", 16'h0032, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000);
    short2();
    check_pop();

    // Simultaneous press1 and release2 at digit 0 with value 0x00F0.
    do_reset();
    tick(2);
    short2();
    for (int r = 0; r < 15; r++) press1_clean();
    for (int r = 0; r < 3; r++) short2();
    expect_out("simul_setup", 16'h00F0, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check_pop();
    btn2_n = 1'b0;
    tick(8);
    btn1_n = 1'b0;
    btn2_n = 1'b1;
    expect_out("simul", 16'h00F1, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick(12);
    check_pop();
    btn1_n = 1'b1;
    tick(12);

    // Reset mid-SEND drops the offer; arg_ready afterwards has no effect.
    btn2_n = 1'b0;
    expect_out("pre_reset_send", 16'h00F1, 2'd1, 1'b1, 1'b1, 1'b1, 16'h00F1);
    tick(30);
    check_pop();
    reset = 1'b1;
    btn2_n = 1'b1;
    expect_out("reset_send", 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick(1);
    check_pop();
    reset = 1'b0;
    arg_ready = 1'b1;
    expect_out("ready_ignored", 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick(5);
    arg_ready = 1'b0;
    check_pop();
    expect_out("edit_after_reset", 16'h0001, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
    press1_clean();
    check_pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
